// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single byte-enabled data BRAM port.
// Port 1 can take a lock to run uninterrupted bursts (e.g. loader image writes).
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_OPEN    | no lock held; round-robin between valid requesters
// ST_LOCK_P0 | port 0 holds the lock; port 1 is blocked
// ST_LOCK_P1 | port 1 holds the lock; port 0 is blocked
module dmem_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_COL    = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [1:0]                 req_valid_i,
   output logic [1:0]                 req_ready_o,
   input  logic [1:0]                 req_lock_i,
   input  logic [1:0][ADDR_WIDTH-1:0] req_addr_i,
   input  logic [1:0][NUM_COL-1:0]    req_be_i,
   input  logic [1:0][DATA_WIDTH-1:0] req_wdata_i,
   output logic [1:0]                 rsp_valid_o,
   output logic [1:0][DATA_WIDTH-1:0] rsp_rdata_o,
   output logic [NUM_COL-1:0]         mem_wr_en_o,
   output logic [ADDR_WIDTH-1:0]      mem_addr_o,
   output logic [DATA_WIDTH-1:0]      mem_wr_data_o,
   input  logic [DATA_WIDTH-1:0]      mem_rd_data_i
);

   typedef enum logic [1:0] {
      ST_OPEN    = 2'd0,
      ST_LOCK_P0 = 2'd1,
      ST_LOCK_P1 = 2'd2
   } lock_state_e;

   lock_state_e state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic [1:0]  rsp_pending_q, rsp_pending_d;
   logic [1:0]  grant;
   logic        xfer;
   logic        gsel;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^{req_addr_i[0][1:0], req_addr_i[1][1:0]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_OPEN;
         last_grant_q  <= 1'b1;
         rsp_pending_q <= 2'b00;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         rsp_pending_q <= rsp_pending_d;
      end
   end

   always_comb begin
      grant         = 2'b00;
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      rsp_pending_d = 2'b00;

      case (state_q)
         ST_LOCK_P0: grant = 2'b01;
         ST_LOCK_P1: grant = 2'b10;
         default: begin
            case (req_valid_i)
               2'b01:   grant = 2'b01;
               2'b10:   grant = 2'b10;
               2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
               default: grant = 2'b00;
            endcase
         end
      endcase

      req_ready_o = req_valid_i & grant & {2{~rst_i}};
      xfer        = |req_ready_o;
      // With no transfer this selects port 0, which is the idle address view.
      gsel        = req_ready_o[1];

      mem_addr_o    = {req_addr_i[gsel][ADDR_WIDTH-1:2], 2'b00};
      mem_wr_data_o = req_wdata_i[gsel];
      mem_wr_en_o   = xfer ? req_be_i[gsel] : '0;

      if (xfer) begin
         last_grant_d = gsel;
         if (req_lock_i[gsel])
            state_d = gsel ? ST_LOCK_P1 : ST_LOCK_P0;
         else
            state_d = ST_OPEN;
         if (req_be_i[gsel] == '0)
            rsp_pending_d = req_ready_o;
      end
   end

   // A reset landing in the response cycle drops the response as well.
   assign rsp_valid_o    = rsp_pending_q & {2{~rst_i}};
   assign rsp_rdata_o[0] = mem_rd_data_i;
   assign rsp_rdata_o[1] = mem_rd_data_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset-mid-lock sequence and
// randomized traffic against a transaction-level arbitration/memory model.
module tb_dmem_arbiter;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int NC = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [1:0]          req_valid, req_ready, req_lock, rsp_valid;
   logic [1:0][AW-1:0]  req_addr;
   logic [1:0][NC-1:0]  req_be;
   logic [1:0][DW-1:0]  req_wdata, rsp_rdata;
   logic [NC-1:0]       mem_wr_en;
   logic [AW-1:0]       mem_addr;
   logic [DW-1:0]       mem_wr_data, mem_rd_data;

   dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_COL(NC)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_lock_i(req_lock),
      .req_addr_i(req_addr), .req_be_i(req_be), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
      .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr),
      .mem_wr_data_o(mem_wr_data), .mem_rd_data_i(mem_rd_data)
   );

   // Byte-enabled BRAM with one-cycle registered read.
   logic [DW-1:0] bram [1024];
   always @(posedge clk) begin
      for (int c = 0; c < NC; c++)
         if (mem_wr_en[c]) bram[mem_addr[AW-1:2]][8*c +: 8] <= mem_wr_data[8*c +: 8];
      mem_rd_data <= bram[mem_addr[AW-1:2]];
   end

   typedef struct {
      logic        rst;
      logic [1:0]  valid, lock;
      logic [11:0] a0, a1;
      logic [3:0]  be0, be1;
      logic [31:0] wd0, wd1;
      logic [1:0]  e_ready;
      logic [11:0] e_maddr;
      logic [3:0]  e_wen;
      logic [1:0]  e_rspv;
      logic [31:0] e_rdata;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: arbitration policy and a word-array memory.
   logic [31:0] ref_mem [1024];
   int          m_last  = 1;
   int          m_owner = -1;
   int          m_pend  = -1;
   logic [31:0] m_pdata = '0;

   function automatic vec_t mkv(logic r, logic [1:0] v, logic [1:0] l,
                                logic [11:0] a0, logic [11:0] a1,
                                logic [3:0] b0, logic [3:0] b1,
                                logic [31:0] w0, logic [31:0] w1,
                                logic [1:0] er, logic [11:0] ema, logic [3:0] ew,
                                logic [1:0] erv, logic [31:0] erd);
      vec_t t;
      t.rst = r; t.valid = v; t.lock = l; t.a0 = a0; t.a1 = a1;
      t.be0 = b0; t.be1 = b1; t.wd0 = w0; t.wd1 = w1;
      t.e_ready = er; t.e_maddr = ema; t.e_wen = ew; t.e_rspv = erv; t.e_rdata = erd;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input bit use_tab);
      int          g;
      logic [1:0]  m_ready, m_rspv;
      logic [11:0] m_maddr;
      logic [3:0]  m_wen;
      rst = v.rst; req_valid = v.valid; req_lock = v.lock;
      req_addr[0] = v.a0; req_addr[1] = v.a1;
      req_be[0] = v.be0; req_be[1] = v.be1;
      req_wdata[0] = v.wd0; req_wdata[1] = v.wd1;
      @(negedge clk);

      g = -1;
      if (!v.rst) begin
         if (m_owner >= 0) begin
            if (req_valid[m_owner]) g = m_owner;
         end else if (req_valid == 2'b11) g = 1 - m_last;
         else if (req_valid[0]) g = 0;
         else if (req_valid[1]) g = 1;
      end
      m_ready = 2'b00;
      m_wen   = 4'h0;
      m_maddr = {req_addr[0][11:2], 2'b00};
      if (g >= 0) begin
         m_ready[g] = 1'b1;
         m_wen      = req_be[g];
         m_maddr    = {req_addr[g][11:2], 2'b00};
      end
      m_rspv = 2'b00;
      if (m_pend >= 0 && !v.rst) m_rspv[m_pend] = 1'b1;

      chk("model_ready", 32'(req_ready), 32'(m_ready));
      chk("model_maddr", 32'(mem_addr), 32'(m_maddr));
      chk("model_wen", 32'(mem_wr_en), 32'(m_wen));
      chk("model_rspv", 32'(rsp_valid), 32'(m_rspv));
      if (m_rspv != 2'b00) chk("model_rdata", rsp_rdata[m_pend], m_pdata);
      if (g >= 0) chk("model_wdata", mem_wr_data, req_wdata[g]);

      if (use_tab) begin
         chk("tab_ready", 32'(req_ready), 32'(v.e_ready));
         chk("tab_maddr", 32'(mem_addr), 32'(v.e_maddr));
         chk("tab_wen", 32'(mem_wr_en), 32'(v.e_wen));
         chk("tab_rspv", 32'(rsp_valid), 32'(v.e_rspv));
         if (v.e_rspv != 2'b00) chk("tab_rdata", rsp_rdata[v.e_rspv[1]], v.e_rdata);
      end

      if (v.rst) begin
         m_last = 1; m_owner = -1; m_pend = -1;
      end else begin
         m_pend = -1;
         if (g >= 0) begin
            m_last  = g;
            m_owner = req_lock[g] ? g : -1;
            if (req_be[g] == 4'h0) begin
               m_pend  = g;
               m_pdata = ref_mem[req_addr[g][11:2]];
            end else begin
               for (int c = 0; c < 4; c++)
                  if (req_be[g][c]) ref_mem[req_addr[g][11:2]][8*c +: 8] = req_wdata[g][8*c +: 8];
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tab [18];
   vec_t rv;

   initial begin
      tab[0]  = mkv(0, 2'b01, 2'b00, 12'h010, 12'h000, 4'h0, 4'h0, 0, 0,            2'b01, 12'h010, 4'h0, 2'b00, 0);
      tab[1]  = mkv(0, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 4'h0, 0, 0,            2'b00, 12'h000, 4'h0, 2'b01, 32'hDEADBEEF);
      tab[2]  = mkv(0, 2'b11, 2'b00, 12'h004, 12'h008, 4'h0, 4'h0, 0, 0,            2'b10, 12'h008, 4'h0, 2'b00, 0);
      tab[3]  = mkv(0, 2'b11, 2'b00, 12'h004, 12'h008, 4'h0, 4'h0, 0, 0,            2'b01, 12'h004, 4'h0, 2'b10, 32'hA5A50002);
      tab[4]  = mkv(0, 2'b11, 2'b00, 12'h004, 12'h008, 4'h0, 4'h0, 0, 0,            2'b10, 12'h008, 4'h0, 2'b01, 32'hA5A50001);
      tab[5]  = mkv(0, 2'b11, 2'b00, 12'h004, 12'h008, 4'h0, 4'h0, 0, 0,            2'b01, 12'h004, 4'h0, 2'b10, 32'hA5A50002);
      tab[6]  = mkv(0, 2'b10, 2'b00, 12'h000, 12'h022, 4'h0, 4'b0100, 0, 32'h00AB0000, 2'b10, 12'h020, 4'b0100, 2'b01, 32'hA5A50001);
      tab[7]  = mkv(0, 2'b10, 2'b00, 12'h000, 12'h020, 4'h0, 4'h0, 0, 0,            2'b10, 12'h020, 4'h0, 2'b00, 0);
      tab[8]  = mkv(0, 2'b00, 2'b00, 12'h013, 12'h000, 4'h0, 4'h0, 0, 0,            2'b00, 12'h010, 4'h0, 2'b10, 32'h11AB3344);
      tab[9]  = mkv(0, 2'b01, 2'b00, 12'h013, 12'h000, 4'h0, 4'h0, 0, 0,            2'b01, 12'h010, 4'h0, 2'b00, 0);
      tab[10] = mkv(0, 2'b11, 2'b10, 12'h004, 12'h030, 4'h0, 4'hF, 0, 32'hC0000001, 2'b10, 12'h030, 4'hF, 2'b01, 32'hDEADBEEF);
      tab[11] = mkv(0, 2'b11, 2'b10, 12'h004, 12'h034, 4'h0, 4'hF, 0, 32'hC0000002, 2'b10, 12'h034, 4'hF, 2'b00, 0);
      tab[12] = mkv(0, 2'b01, 2'b10, 12'h004, 12'h038, 4'h0, 4'hF, 0, 32'hC0000003, 2'b00, 12'h004, 4'h0, 2'b00, 0);
      tab[13] = mkv(0, 2'b11, 2'b10, 12'h004, 12'h038, 4'h0, 4'hF, 0, 32'hC0000003, 2'b10, 12'h038, 4'hF, 2'b00, 0);
      tab[14] = mkv(0, 2'b11, 2'b00, 12'h004, 12'h03C, 4'h0, 4'hF, 0, 32'hC0000004, 2'b10, 12'h03C, 4'hF, 2'b00, 0);
      tab[15] = mkv(0, 2'b11, 2'b00, 12'h004, 12'h030, 4'h0, 4'h0, 0, 0,            2'b01, 12'h004, 4'h0, 2'b00, 0);
      tab[16] = mkv(0, 2'b10, 2'b00, 12'h004, 12'h030, 4'h0, 4'h0, 0, 0,            2'b10, 12'h030, 4'h0, 2'b01, 32'hA5A50001);
      tab[17] = mkv(0, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 4'h0, 0, 0,            2'b00, 12'h000, 4'h0, 2'b10, 32'hC0000001);

      for (int i = 0; i < 1024; i++) begin
         bram[i]    = 32'hA5A50000 | 32'(i);
         ref_mem[i] = 32'hA5A50000 | 32'(i);
      end
      bram[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
      bram[8] = 32'h11223344; ref_mem[8] = 32'h11223344;

      rst = 1'b1; req_valid = '0; req_lock = '0; req_addr = '0; req_be = '0; req_wdata = '0;
      @(posedge clk);
      #1;

      // Reset held with write traffic present: nothing accepted, nothing written.
      for (int i = 0; i < 2; i++)
         step(mkv(1, 2'b11, 2'b00, 12'h040, 12'h044, 4'hF, 4'hF, 32'hFFFFFFFF, 32'hEEEEEEEE,
                  2'b00, 12'h040, 4'h0, 2'b00, 0), 1'b1);

      for (int i = 0; i < 18; i++) step(tab[i], 1'b1);

      // Reset mid-lock with a read response due in the reset cycle.
      step(mkv(0, 2'b10, 2'b10, 12'h000, 12'h008, 4'h0, 4'h0, 0, 0, 2'b10, 12'h008, 4'h0, 2'b00, 0), 1'b1);
      step(mkv(1, 2'b11, 2'b10, 12'h040, 12'h008, 4'hF, 4'h0, 32'hFFFFFFFF, 0, 2'b00, 12'h040, 4'h0, 2'b00, 0), 1'b1);
      step(mkv(0, 2'b11, 2'b00, 12'h004, 12'h008, 4'h0, 4'h0, 0, 0, 2'b01, 12'h004, 4'h0, 2'b00, 0), 1'b1);
      step(mkv(0, 2'b11, 2'b00, 12'h004, 12'h008, 4'h0, 4'h0, 0, 0, 2'b10, 12'h008, 4'h0, 2'b01, 32'hA5A50001), 1'b1);
      step(mkv(0, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 4'h0, 0, 0, 2'b00, 12'h000, 4'h0, 2'b10, 32'hA5A50002), 1'b1);

      for (int i = 0; i < 400; i++) begin
         rv = mkv(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)),
                  {($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0)},
                  12'($urandom_range(0, 63)), 12'($urandom_range(0, 63)),
                  ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                  $urandom, $urandom, 2'b00, 12'h000, 4'h0, 2'b00, 0);
         step(rv, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester round-robin arbiter that shares the single byte-enabled 1R1W data BRAM port between the LSU (port 0) and the program loader/debug master (port 1).
- Each requester uses a valid/ready request channel and receives a registered one-cycle read response.
- Supports a lock so that port 1 can perform uninterrupted multi-word bursts, e.g. image load before release of reset to the core.
- Sits between the LSU/loader and the data memory instance.

Parameters:
ADDR_WIDTH, 12, byte-address bits used; word index is ADDR_WIDTH-1:2
DATA_WIDTH, 32, word width
NUM_COL, 4, byte-enable columns (DATA_WIDTH/8)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  2  request valid per port
req_ready  out  2  request accepted this cycle per port
req_lock  in  2  hold grant after this transfer
req_addr  in  2xADDR_WIDTH  byte address per port
req_be  in  2xNUM_COL  byte enables; all zero = read
req_wdata  in  2xDATA_WIDTH  lane-aligned write data
rsp_valid  out  2  read data valid per port
rsp_rdata  out  2xDATA_WIDTH  read word per port
mem_wr_en  out  NUM_COL  BRAM byte write enables
mem_addr  out  ADDR_WIDTH  BRAM address, word aligned
mem_wr_data  out  DATA_WIDTH  BRAM write data
mem_rd_data  in  DATA_WIDTH  BRAM read data, one cycle after address

Behaviour:
- **State:**
  - last_grant (1b), reset 1, so port 0 wins first contention.
  - locked (1b), reset 0.
  - lock_owner (1b), reset 0.
  - rsp_pending (2b), reset 0.
  - rsp_valid is registered and resets to 0.
- **Grant (combinational, same cycle):**
  - locked=1: only lock_owner is eligible; the other port's ready=0 even if lock_owner is idle.
  - locked=0, one valid: that port is granted.
  - locked=0, both valid: port != last_grant is granted.
  - req_ready[g] = req_valid[g] & grant[g] & ~rst; at most one ready bit is high.
- **Memory drive:**
  - mem_addr = {granted addr[ADDR_WIDTH-1:2], 2'b00}.
  - mem_wr_data = granted wdata.
  - mem_wr_en = granted be when a transfer is accepted, else 0.
  - With no transfer, mem_addr holds port 0's address; mem_wr_en = 0.
- **Accepted transfer (req_valid & req_ready):**
  - last_grant <= g.
  - If req_lock[g]=1: locked <= 1, lock_owner <= g.
  - If req_lock[g]=0 and locked: locked <= 0, released after this transfer.
  - Idle cycles never change last_grant or the lock.
- **Read response:**
  - A read accepted in cycle N sets rsp_valid[g]=1 in cycle N+1 only.
  - rsp_rdata[g] = mem_rd_data in that cycle, full word; byte/half extraction is left to the requester.
  - Back-to-back reads give back-to-back responses.
  - Writes produce no response.
  - rsp_rdata is don't-care when rsp_valid=0; it drives mem_rd_data on both ports.
- **Read-after-write:**
  - Read-after-write to the same word in consecutive cycles returns the new data, because the write commits before the next read edge.
  - The BRAM read-during-write (same cycle) value is not relied on, since a single grant prevents it.
- **Boundaries:**
  - Both ports are never granted in one cycle.
  - A locked owner may issue lock=1 indefinitely; the other port starves by design.
  - A requester dropping valid while not ready is legal; there is no request state.
- **Reset:** rst asserted at any time, including mid-lock or with a response pending:
  - next cycle locked=0, last_grant=1, rsp_valid=0; pending responses are dropped.
  - During rst, req_ready=0 and mem_wr_en=0.
- **Latency:** grant 0 cycles; read data 1 cycle after acceptance.
- No throughput loss: one transfer per cycle.

Test Plan:
- Port 0 alone reads 0x010 after a word 0xDEADBEEF has been preloaded: ready[0]=1 in cycle N; rsp_valid[0]=1 with rdata 0xDEADBEEF in N+1 only; rsp_valid[1]=0.
- Contention:
  - Both ports continuously request reads of distinct words from reset.
  - Grants alternate 0,1,0,1.
  - Each response returns on the owning port one cycle later.
- Byte write:
  - Port 1 writes be=4'b0100, wdata 0x00AB0000 to 0x022 over prior 0x11223344.
  - A following read returns 0x11AB3344 next cycle.
- Lock:
  - Port 1 issues 4 writes with lock=1,1,1,0 while port 0 is valid throughout.
  - Port 0 ready=0 for all 4 cycles, granted in the 5th cycle.
  - A lock-owner idle cycle keeps port 0 blocked.
- Reset mid-lock:
  - rst is asserted while port 1 is locked and a read response is pending.
  - No rsp_valid appears; after reset, with both ports valid, port 0 is granted first.
- Misaligned address 0x013 read: mem_addr=0x010; full word returned.
